count_seq_checker: RTL
======================

// Module: count_seq_checker
// PURPOSE
//  Consumer and checker for the free-running lab2 4-bit up-counter output.
//  Samples the count bus, acquires lock on the +1 modulo-2^WIDTH sequence, flags
//  every break in that sequence, and keeps a saturating error tally.
//  Sits beside the lab2 counter in the lab top level. Drives LEDs and bench assertions.
// PARAMETERS
//  WIDTH     4   width of observed count bus
//  LOCK_CNT  3   consecutive in-sequence samples needed to declare lock (>=2)
//  ERR_W     8   width of saturating error counter
// PORTS
//  mainClock  in   1        system clock, rising edge
//  reset      in   1        synchronous, active-low reset
//  count_in   in   WIDTH    observed counter value
//  sample_en  in   1        1 = count_in valid this cycle; 0 = cycle ignored
//  locked     out  1        sequence lock acquired
//  err_pulse  out  1        one-cycle pulse: sequence break detected while locked
//  wrap_pulse out  1        one-cycle pulse: locked and in-sequence max (all-ones) sample
//  err_count  out  ERR_W    saturating count of err_pulse events
//  expected   out  WIDTH    next value the checker expects
// BEHAVIOUR
//  - All outputs are registered. Sampled on the mainClock rising edge.
//  - Reset (reset==0 at the edge) has priority over everything, including mid-lock.
//    - state=IDLE, locked=0, err_pulse=0, wrap_pulse=0, err_count=0, expected=0, match counter=0.
//    - sample_en is ignored during reset.
//  - A cycle with sample_en==0 changes no state.
//    - err_pulse and wrap_pulse still return to 0.
//  - Match means count_in == expected. Comparison is modulo 2^WIDTH.
//  - Latency: response to a sample appears at the next edge (1 cycle).
//  - All arithmetic is WIDTH-bit and wraps. expected after all-ones is 0.
//  - State machine: IDLE, SYNC, LOCKED.
//    - IDLE, sample: expected<=count_in+1, mcnt<=1, go SYNC.
//    - SYNC, match: expected<=expected+1, mcnt<=mcnt+1.
//      If mcnt+1==LOCK_CNT, go LOCKED and set locked<=1.
//    - SYNC, mismatch: expected<=count_in+1, mcnt<=1, stay SYNC. No err_pulse.
//    - LOCKED, match: expected<=expected+1.
//      wrap_pulse<=1 if count_in is all-ones.
//    - LOCKED, mismatch: err_pulse<=1, err_count<=err_count+1 (sat. at 2^ERR_W-1).
//      Also locked<=0, expected<=count_in+1, mcnt<=1, go SYNC.
//  - A counter reset seen as a jump to 0 while locked is a mismatch, same as any break.
//  - A held (repeated) value while locked is a mismatch.
//  - At most one err_pulse per break. Re-errors need lock re-acquired first.
//  - Saturated err_count holds. err_pulse still fires.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles, any inputs.
//    -> all outputs 0. Next edge after release, state still IDLE.
//  2 Lock acquire: sample_en=1, count_in=5,6,7.
//    -> locked=1 one cycle after the sample of 7, expected=8.
//  3 Wrap: locked, feed 14,15,0,1.
//    -> wrap_pulse=1 for exactly one cycle after 15, err_pulse stays 0, locked stays 1.
//  4 Break: locked at expected=9, feed 3.
//    -> err_pulse=1 one cycle, err_count=1, locked=0, expected=4.
//    Then 4,5 -> locked=1 again.
//  5 Gaps: locked, interleave sample_en=0 cycles with garbage count_in.
//    -> no state change, no pulses, sequence continues on valid samples.
//  6 Saturation + mid-op reset: ERR_W=2, force 4 breaks.
//    -> err_count=3 held, err_pulse 4 times. Then reset=0 while locked -> all outputs 0 next edge.

Source files
------------

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - lock-and-check monitor for a free-running +1 counter bus
//
// Purpose:
//   Samples an observed counter bus, acquires lock once LOCK_CNT consecutive
//   samples follow the +1 modulo-2^WIDTH sequence, reports every break in that
//   sequence while locked, and keeps a saturating tally of breaks.
//
// Ports:
//   mainClock   in   1      system clock, rising edge
//   reset       in   1      synchronous active-low reset
//   count_in    in   WIDTH  observed counter value
//   sample_en   in   1      count_in is valid this cycle
//   locked      out  1      sequence lock held
//   err_pulse   out  1      one-cycle pulse on a sequence break while locked
//   wrap_pulse  out  1      one-cycle pulse on an in-sequence all-ones sample while locked
//   err_count   out  ERR_W  saturating count of err_pulse events
//   expected    out  WIDTH  next value the checker expects
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             mainClock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             sample_en,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Match counter only needs to reach LOCK_CNT.
  localparam int               MCW      = $clog2(LOCK_CNT + 1);
  localparam logic [MCW-1:0]   LOCK_TGT = MCW'(LOCK_CNT);
  localparam logic [MCW-1:0]   MCNT_ONE = MCW'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             match;
  logic [MCW-1:0]   mcnt_inc;

  assign match    = (count_in == expected_q);
  assign mcnt_inc = mcnt_q + MCNT_ONE;

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    mcnt_d       = mcnt_q;
    locked_d     = locked_q;
    err_count_d  = err_count_q;
    // Pulses drop back to 0 on every cycle unless re-asserted below.
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;

    if (sample_en) begin
      unique case (state_q)
        S_IDLE: begin
          expected_d = count_in + CNT_ONE;
          mcnt_d     = MCNT_ONE;
          state_d    = S_SYNC;
        end

        S_SYNC: begin
          if (match) begin
            expected_d = expected_q + CNT_ONE;
            mcnt_d     = mcnt_inc;
            if (mcnt_inc == LOCK_TGT) begin
              state_d  = S_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            // Re-seed on the new value; breaks before lock are not errors.
            expected_d = count_in + CNT_ONE;
            mcnt_d     = MCNT_ONE;
          end
        end

        S_LOCKED: begin
          if (match) begin
            expected_d   = expected_q + CNT_ONE;
            wrap_pulse_d = (count_in == ALL_ONES);
          end else begin
            // Dropping to SYNC guarantees a single err_pulse per break.
            err_pulse_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_ONE;
            end
            locked_d   = 1'b0;
            expected_d = count_in + CNT_ONE;
            mcnt_d     = MCNT_ONE;
            state_d    = S_SYNC;
          end
        end

        default: begin
          state_d  = S_IDLE;
          locked_d = 1'b0;
          mcnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge mainClock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      expected_q   <= '0;
      mcnt_q       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      mcnt_q       <= mcnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;
  assign expected   = expected_q;

endmodule
